// File: rtl/xor_pkg.sv
// Shared constants, state encoding and helpers for the XOR frame LRC block.
package xor_pkg;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Counter increment that sticks at max_val instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/xor_fold.sv
// Combinational XOR reduction of a WIDTH-bit word to a single parity bit.
module xor_fold
    import xor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_data,
    output logic             o_parity
);

    // Reduction XOR maps onto a balanced tree in synthesis for any WIDTH.
    assign o_parity = ^i_data;

endmodule

// File: rtl/xor_frame_lrc.sv
// Streaming per-frame XOR LRC generator with folded parity and saturating word count.
// Optional expected-LRC compare (in_expect/out_err) when XOR_FRAME_LRC_CHECK_EN is defined.
module xor_frame_lrc
    import xor_pkg::*;
#(
    parameter int   WIDTH       = 8,
    parameter int   CNT_W       = 8,
    parameter logic ODD_DEFAULT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             cfg_odd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_lrc,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_count
`ifdef XOR_FRAME_LRC_CHECK_EN
    ,
    input  logic [WIDTH-1:0] in_expect,
    output logic             out_err
`endif
);

    localparam logic [31:0] CNT_MAX   = (32'd1 << CNT_W) - 32'd1;
    localparam logic        RST_SENSE = ODD_DEFAULT ? PARITY_ODD : PARITY_EVEN;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_odd;
    logic [WIDTH-1:0]   r_lrc;
    logic [CNT_W-1:0]   r_count;
    logic               r_parity;

    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_first;
    logic               w_sense;
    logic [WIDTH-1:0]   w_lrc_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_fold;

    assign out_valid  = (r_state == ST_HOLD);
    assign in_ready   = !out_valid || out_ready;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    // The counter never wraps, so zero reliably marks the first beat of a frame.
    assign w_first   = (r_cnt == '0);
    assign w_sense   = w_first ? cfg_odd : r_odd;
    assign w_lrc_nxt = r_acc ^ in_data;
    assign w_cnt_nxt = CNT_W'(sat_inc(32'(r_cnt), CNT_MAX));

    xor_fold #(
        .WIDTH (WIDTH)
    ) u_fold (
        .i_data   (w_lrc_nxt),
        .o_parity (w_fold)
    );

    always_comb begin
        // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            ST_ACCUM: if (w_in_fire && in_last) w_state_nxt = ST_HOLD;
            ST_HOLD:  if (w_out_fire && !(w_in_fire && in_last)) w_state_nxt = ST_ACCUM;
            default:  w_state_nxt = ST_ACCUM;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_ACCUM;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_cnt    <= '0;
            r_odd    <= RST_SENSE;
            r_lrc    <= '0;
            r_count  <= '0;
            r_parity <= RST_SENSE;
        end else if (w_in_fire) begin
            if (w_first) r_odd <= cfg_odd;
            if (in_last) begin
                r_lrc    <= w_lrc_nxt;
                r_count  <= w_cnt_nxt;
                r_parity <= w_fold ^ w_sense;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else begin
                r_acc <= w_lrc_nxt;
                r_cnt <= w_cnt_nxt;
            end
        end
    end

    assign out_lrc    = r_lrc;
    assign out_count  = r_count;
    assign out_parity = r_parity;

`ifdef XOR_FRAME_LRC_CHECK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst)                       r_err <= 1'b0;
        else if (w_in_fire && in_last) r_err <= (w_lrc_nxt != in_expect);
    end

    assign out_err = r_err;
`endif

endmodule

// File: tb/tb_xor_frame_lrc.sv
// Self-checking bench for xor_frame_lrc: directed scenarios plus randomized traffic vs a frame-level model.
module tb_xor_frame_lrc;

    typedef struct {
        logic [7:0] lrc;
        logic [7:0] cnt;
        logic [1:0] cnt_s;
        logic       par;
        logic       err;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_last = 1'b0;
    logic       cfg_odd = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] in_expect = '0;

    logic       in_ready, out_valid, out_parity;
    logic [7:0] out_lrc, out_count;
    logic       in_ready_s, out_valid_s, out_parity_s;
    logic [7:0] out_lrc_s;
    logic [1:0] out_count_s;
    logic       out_err, out_err_s;

    int checks = 0;
    int errors = 0;

    logic [7:0] frame_q[$];
    res_t       res_q[$];
    logic       frame_odd;

    always #5 clk = ~clk;

    xor_frame_lrc #(.WIDTH(8), .CNT_W(8), .ODD_DEFAULT(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .cfg_odd(cfg_odd),
        .out_valid(out_valid), .out_ready(out_ready), .out_lrc(out_lrc),
        .out_parity(out_parity), .out_count(out_count)
`ifdef XOR_FRAME_LRC_CHECK_EN
        , .in_expect(in_expect), .out_err(out_err)
`endif
    );

    xor_frame_lrc #(.WIDTH(8), .CNT_W(2), .ODD_DEFAULT(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .in_last(in_last), .cfg_odd(cfg_odd),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_lrc(out_lrc_s),
        .out_parity(out_parity_s), .out_count(out_count_s)
`ifdef XOR_FRAME_LRC_CHECK_EN
        , .in_expect(in_expect), .out_err(out_err_s)
`endif
    );

`ifndef XOR_FRAME_LRC_CHECK_EN
    assign out_err   = 1'b0;
    assign out_err_s = 1'b0;
`endif

    function automatic logic [7:0] xor_q();
        logic [7:0] x = '0;
        foreach (frame_q[i]) x = x ^ frame_q[i];
        return x;
    endfunction

    function automatic res_t model_result(input logic odd, input logic [7:0] expect_v);
        res_t r;
        int   n = frame_q.size();
        r.lrc   = xor_q();
        r.cnt   = 8'((n > 255) ? 255 : n);
        r.cnt_s = 2'((n > 3) ? 3 : n);
        r.par   = (^r.lrc) ^ odd;
        r.err   = (r.lrc != expect_v);
        return r;
    endfunction

    task automatic send_beat(input logic [7:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_lrc, out_count, out_parity, in_ready} !== {1'b0, 8'h00, 8'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_main: got v=%b lrc=%h cnt=%0d par=%b rdy=%b want 0/00/0/0/1",
                     out_valid, out_lrc, out_count, out_parity, in_ready);
        end
        checks++;
        if ({out_valid_s, out_lrc_s, out_count_s, out_parity_s, out_err, out_err_s} !== {1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_sat: got v=%b lrc=%h cnt=%0d par=%b err=%b/%b want 0/00/0/1/0/0",
                     out_valid_s, out_lrc_s, out_count_s, out_parity_s, out_err, out_err_s);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        cfg_odd   = 1'b0;
        send_beat(8'h0F, 1'b0);
        cfg_odd = 1'b1;
        send_beat(8'hF0, 1'b0);
        send_beat(8'h3C, 1'b1);
        checks++;
        if ({out_valid, out_lrc, out_count, out_parity} !== {1'b1, 8'hC3, 8'd3, 1'b0}) begin
            errors++;
            $display("FAIL basic_frame: got v=%b lrc=%h cnt=%0d par=%b want 1/c3/3/0",
                     out_valid, out_lrc, out_count, out_parity);
        end
        send_beat(8'h01, 1'b1);
        checks++;
        if ({out_valid, out_lrc, out_count, out_parity} !== {1'b1, 8'h01, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL single_01_odd: got v=%b lrc=%h cnt=%0d par=%b want 1/01/1/0",
                     out_valid, out_lrc, out_count, out_parity);
        end
        send_beat(8'h03, 1'b1);
        checks++;
        if ({out_valid, out_lrc, out_count, out_parity} !== {1'b1, 8'h03, 8'd1, 1'b1}) begin
            errors++;
            $display("FAIL single_03_odd: got v=%b lrc=%h cnt=%0d par=%b want 1/03/1/1",
                     out_valid, out_lrc, out_count, out_parity);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_basic: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        cfg_odd   = 1'b1;
        send_beat(8'h5A, 1'b0);
        cfg_odd = 1'b0;
        send_beat(8'hC3, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h77;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid, out_lrc, out_count, out_parity, in_ready} !== {1'b1, 8'h99, 8'd2, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b lrc=%h cnt=%0d par=%b rdy=%b want 1/99/2/1/0",
                         i, out_valid, out_lrc, out_count, out_parity, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        in_data   = 8'hAA;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready: got in_ready=%b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if ({out_valid, out_lrc, out_count, out_parity} !== {1'b1, 8'hAA, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL back_to_back: got v=%b lrc=%h cnt=%0d par=%b want 1/aa/1/0",
                     out_valid, out_lrc, out_count, out_parity);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_bp: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_saturation();
        cfg_odd = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(8'h01, 1'b0);
        send_beat(8'h01, 1'b1);
        checks++;
        if ({out_valid, out_lrc, out_count, out_parity} !== {1'b1, 8'h01, 8'd5, 1'b1}) begin
            errors++;
            $display("FAIL five_words: got v=%b lrc=%h cnt=%0d par=%b want 1/01/5/1",
                     out_valid, out_lrc, out_count, out_parity);
        end
        checks++;
        if ({out_valid_s, out_lrc_s, out_count_s, out_parity_s} !== {1'b1, 8'h01, 2'd3, 1'b1}) begin
            errors++;
            $display("FAIL count_saturate: got v=%b lrc=%h cnt=%0d par=%b want 1/01/3/1",
                     out_valid_s, out_lrc_s, out_count_s, out_parity_s);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midframe();
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, out_valid_s} !== 2'b00) begin
                errors++;
                $display("FAIL reset_no_valid[%0d]: got %b/%b want 0/0", i, out_valid, out_valid_s);
            end
        end
        rst     = 1'b0;
        cfg_odd = 1'b0;
        send_beat(8'h55, 1'b1);
        checks++;
        if ({out_valid, out_lrc, out_count, out_parity, out_lrc_s, out_count_s} !== {1'b1, 8'h55, 8'd1, 1'b0, 8'h55, 2'd1}) begin
            errors++;
            $display("FAIL after_reset_frame: got v=%b lrc=%h cnt=%0d par=%b sat=%h/%0d want 1/55/1/0 55/1",
                     out_valid, out_lrc, out_count, out_parity, out_lrc_s, out_count_s);
        end
        @(posedge clk); #1;
    endtask

`ifdef XOR_FRAME_LRC_CHECK_EN
    task automatic test_check_en();
        in_expect = 8'h26;
        send_beat(8'h12, 1'b0);
        send_beat(8'h34, 1'b1);
        checks++;
        if ({out_lrc, out_err, out_err_s} !== {8'h26, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL check_match: got lrc=%h err=%b/%b want 26/0/0", out_lrc, out_err, out_err_s);
        end
        in_expect = 8'h27;
        send_beat(8'h12, 1'b0);
        send_beat(8'h34, 1'b1);
        checks++;
        if ({out_lrc, out_err, out_err_s} !== {8'h26, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL check_mismatch: got lrc=%h err=%b/%b want 26/1/1", out_lrc, out_err, out_err_s);
        end
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_random();
        logic exp_ready;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        frame_q.delete();
        res_q.delete();
        frame_odd = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            checks++;
            if (out_valid !== (res_q.size() != 0)) begin
                errors++;
                $display("FAIL rnd_valid@%0d: got %b want %b", cyc, out_valid, res_q.size() != 0);
            end
            if (res_q.size() != 0) begin
                checks++;
                if ({out_lrc, out_count, out_parity, out_lrc_s, out_count_s, out_parity_s} !==
                    {res_q[0].lrc, res_q[0].cnt, res_q[0].par, res_q[0].lrc, res_q[0].cnt_s, res_q[0].par}) begin
                    errors++;
                    $display("FAIL rnd_result@%0d: got lrc=%h cnt=%0d par=%b sat_cnt=%0d want lrc=%h cnt=%0d par=%b sat_cnt=%0d",
                             cyc, out_lrc, out_count, out_parity, out_count_s,
                             res_q[0].lrc, res_q[0].cnt, res_q[0].par, res_q[0].cnt_s);
                end
`ifdef XOR_FRAME_LRC_CHECK_EN
                checks++;
                if ({out_err, out_err_s} !== {res_q[0].err, res_q[0].err}) begin
                    errors++;
                    $display("FAIL rnd_err@%0d: got %b/%b want %b", cyc, out_err, out_err_s, res_q[0].err);
                end
`endif
            end
            out_ready = ($urandom_range(99) < 70);
            in_valid  = ($urandom_range(99) < 60);
            in_data   = 8'($urandom);
            in_last   = ($urandom_range(99) < 25);
            cfg_odd   = 1'($urandom);
            in_expect = $urandom_range(1) ? (xor_q() ^ in_data) : 8'($urandom);
            #1;
            exp_ready = (res_q.size() == 0) || out_ready;
            checks++;
            if (in_ready !== exp_ready) begin
                errors++;
                $display("FAIL rnd_ready@%0d: got %b want %b", cyc, in_ready, exp_ready);
            end
            if (res_q.size() != 0 && out_ready) void'(res_q.pop_front());
            if (in_valid && exp_ready) begin
                if (frame_q.size() == 0) frame_odd = cfg_odd;
                frame_q.push_back(in_data);
                if (in_last) begin
                    res_q.push_back(model_result(frame_odd, in_expect));
                    frame_q.delete();
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_saturation();
        test_reset_midframe();
`ifdef XOR_FRAME_LRC_CHECK_EN
        test_check_en();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xor_frame_lrc.md
Name: xor_frame_lrc

Overview:
- Parametrised streaming successor to the fixed 3-input XOR compare.
- Accumulates a bitwise XOR (longitudinal redundancy check, LRC) over every WIDTH-bit word of a frame delimited by in_last.
- Emits one result per frame: LRC word, folded parity bit and word count.
- Sits on data paths as an integrity generator/checker, with valid/ready on both sides.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- CNT_W, 8, width of frame word counter; counter saturates at 2^CNT_W-1.
- ODD_DEFAULT, 0, parity sense after reset: 0 = even, 1 = odd.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept a word
- in_data  input  WIDTH  data word
- in_last  input  1  word is last of frame
- cfg_odd  input  1  parity sense; sampled on first beat of each frame
- out_valid  output  1  frame result valid
- out_ready  input  1  downstream accepts result
- out_lrc  output  WIDTH  XOR of all words in frame
- out_parity  output  1  XOR-reduce(out_lrc) ^ latched cfg_odd
- out_count  output  CNT_W  words in frame (saturating)

Behaviour:
- Clock/reset: one clock domain (clk); rst is synchronous and active-high. Both are fixed.
- Reset:
  - out_valid=0, out_lrc=0, out_parity=ODD_DEFAULT, out_count=0.
  - Accumulator=0, beat counter=0, state=ACCUM, latched parity sense=ODD_DEFAULT.
  - A frame in progress at reset is discarded, with no partial result.
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_ready = !out_valid | out_ready, so back-to-back frames run at full rate.
  - in_ready is 0 while a result is stalled.
- States:
  - ACCUM: in_fire & !in_last: acc <= acc ^ in_data; cnt <= sat(cnt+1); stay.
  - ACCUM: in_fire & in_last: load out_lrc <= acc ^ in_data, out_count <= sat(cnt+1), out_parity per rule above; out_valid <= 1; acc <= 0; cnt <= 0; go to HOLD.
  - HOLD: out_fire without in_fire: out_valid <= 0; go to ACCUM.
  - HOLD: out_fire and in_fire on the same cycle: the new beat is accumulated into the cleared accumulator. If that beat is also in_last, the output registers reload and out_valid stays 1 (single-word frame).
- Latency: result is valid exactly 1 cycle after the in_last beat fires.
- Output stability: outputs hold stable while out_valid & !out_ready.
- Single-word frame: out_lrc=in_data, out_count=1.
- Counter saturation: at 2^CNT_W-1 the count sticks; the LRC remains exact.
- Idle input: in_valid low leaves the accumulator unchanged. Gaps inside a frame are legal.
- cfg_odd: changes mid-frame are ignored until the next frame's first beat.

Optional Feature:
- Macro: XOR_FRAME_LRC_CHECK_EN.
- When defined, adds input in_expect[WIDTH], sampled with the in_last beat, and output out_err[1].
  - out_err = (computed LRC != in_expect), registered alongside out_lrc.
  - out_err resets to 0.
- When undefined: neither port exists and there is no compare logic. All other behaviour is identical.

Decomposition:
- Package xor_pkg:
  - PARITY_EVEN=1'b0 and PARITY_ODD=1'b1 constants.
  - State encoding constants ST_ACCUM/ST_HOLD.
  - Saturating-increment function.
- Sub-module xor_fold:
  - Combinational WIDTH-parameterised XOR reduction tree producing the parity bit.
  - Reused by future parity blocks.

Test Plan:
- WIDTH=8, frame 0x0F,0xF0,0x3C (last), out_ready=1, cfg_odd=0 -> one cycle later out_valid=1, out_lrc=0xC3, out_count=3, out_parity=0.
- Single-word frame 0x01 with cfg_odd=1 -> out_lrc=0x01, out_count=1, out_parity=0. Repeat with 0x03 -> out_parity=1.
- Backpressure: out_ready=0 after a frame completes -> in_ready=0, outputs stable for 5 cycles. Raise out_ready with a new single-word last beat 0xAA on the same cycle -> out_valid stays 1, next out_lrc=0xAA.
- CNT_W=2, 5-word frame of 0x01 -> out_count=3 (saturated), out_lrc=0x01.
- Reset asserted after 2 beats of a frame, then frame 0x55 (last) -> out_lrc=0x55, out_count=1, with no spurious out_valid during reset.
- With XOR_FRAME_LRC_CHECK_EN: frame 0x12,0x34 (last), in_expect=0x26 -> out_err=0. Repeat with in_expect=0x27 -> out_err=1.
